i2c_write_arbiter: RTL and testbench

I2C_WRITE_ARBITER -- requirements
Module: i2c_write_arbiter

---
 rtl/i2c_write_arbiter.sv | 171 +++++++++++++++++
 tb/tb_i2c_write_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_arbiter.sv
// Two-requester arbiter in front of a shared I2C byte writer: captures one byte per
// requester, grants round-robin on ties, and abandons a granted write after TIMEOUT cycles.
module i2c_write_arbiter #(
  parameter int TIMEOUT = 20000
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic       req0_ena,
  input  logic [7:0] req0_data,
  input  logic       req0_cmd_data,
  input  logic [6:0] req0_addr,
  output logic       req0_busy,
  output logic       req0_done,
  input  logic       req1_ena,
  input  logic [7:0] req1_data,
  input  logic       req1_cmd_data,
  input  logic [6:0] req1_addr,
  output logic       req1_busy,
  output logic       req1_done,
  output logic       wr_ena,
  output logic [7:0] wr_data,
  output logic       wr_cmd_data,
  output logic [6:0] wr_addr,
  input  logic       wr_done,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [14:0] CNT_MAX = 15'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  pend_q, pend_d;
  logic [15:0] cap0_q, cap0_d;   // {cmd_data, addr, data}
  logic [15:0] cap1_q, cap1_d;
  logic [15:0] wr_q, wr_d;
  logic        g_q, g_d;
  logic        lg_q, lg_d;
  logic [14:0] cnt_q, cnt_d;
  logic        to_q, to_d;
  logic        wr_ena_q, wr_ena_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        terr_q, terr_d;
  logic        rel0_s, rel1_s;

  assign rel0_s = (state_q == S_RELEASE) && (g_q == 1'b0);
  assign rel1_s = (state_q == S_RELEASE) && (g_q == 1'b1);

  // A new request in the releasing cycle of the same requester beats the clear.
  always_comb begin
    pend_d = pend_q;
    cap0_d = cap0_q;
    cap1_d = cap1_q;
    if (req0_ena && (!pend_q[0] || rel0_s)) begin
      cap0_d    = {req0_cmd_data, req0_addr, req0_data};
      pend_d[0] = 1'b1;
    end else if (rel0_s) begin
      pend_d[0] = 1'b0;
    end else begin
      pend_d[0] = pend_q[0];
    end
    if (req1_ena && (!pend_q[1] || rel1_s)) begin
      cap1_d    = {req1_cmd_data, req1_addr, req1_data};
      pend_d[1] = 1'b1;
    end else if (rel1_s) begin
      pend_d[1] = 1'b0;
    end else begin
      pend_d[1] = pend_q[1];
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    lg_d    = lg_q;
    cnt_d   = 15'd0;
    to_d    = to_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        to_d = 1'b0;
        if (pend_q != 2'b00) begin
          state_d = S_ISSUE;
          if (pend_q == 2'b11) begin
            g_d = ~lg_q;
          end else begin
            g_d = pend_q[1];
          end
          wr_d = g_d ? cap1_q : cap0_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        lg_d    = g_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wr_done) begin
          state_d = S_RELEASE;
          to_d    = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_RELEASE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 15'd1;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    wr_ena_d = (state_d == S_ISSUE);
    done0_d  = (state_d == S_RELEASE) && (g_d == 1'b0);
    done1_d  = (state_d == S_RELEASE) && (g_d == 1'b1);
    terr_d   = (state_d == S_RELEASE) && to_d;
  end

  // State, capture and output registers; lg resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pend_q   <= 2'b00;
      cap0_q   <= 16'h0000;
      cap1_q   <= 16'h0000;
      wr_q     <= 16'h0000;
      g_q      <= 1'b0;
      lg_q     <= 1'b1;
      cnt_q    <= 15'd0;
      to_q     <= 1'b0;
      wr_ena_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      cap0_q   <= cap0_d;
      cap1_q   <= cap1_d;
      wr_q     <= wr_d;
      g_q      <= g_d;
      lg_q     <= lg_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      wr_ena_q <= wr_ena_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      terr_q   <= terr_d;
    end
  end

  assign req0_busy   = pend_q[0];
  assign req1_busy   = pend_q[1];
  assign req0_done   = done0_q;
  assign req1_done   = done1_q;
  assign wr_ena      = wr_ena_q;
  assign wr_cmd_data = wr_q[15];
  assign wr_addr     = wr_q[14:8];
  assign wr_data     = wr_q[7:0];
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Self-checking bench for i2c_write_arbiter: vector table plus directed sequences,
// with a scoreboard of expected writer transactions in predicted grant order.
module tb_i2c_write_arbiter;

  logic       clk_1MHz = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_ena = 1'b0, req0_cmd_data = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic [6:0] req0_addr = 7'h00;
  logic       req1_ena = 1'b0, req1_cmd_data = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic [6:0] req1_addr = 7'h00;
  logic       req0_busy, req0_done, req1_busy, req1_done;
  logic       wr_ena, wr_cmd_data, timeout_err;
  logic [7:0] wr_data;
  logic [6:0] wr_addr;
  logic       wr_done = 1'b0;

  i2c_write_arbiter #(.TIMEOUT(10)) dut (
    .clk_1MHz(clk_1MHz), .rst_n(rst_n),
    .req0_ena(req0_ena), .req0_data(req0_data), .req0_cmd_data(req0_cmd_data),
    .req0_addr(req0_addr), .req0_busy(req0_busy), .req0_done(req0_done),
    .req1_ena(req1_ena), .req1_data(req1_data), .req1_cmd_data(req1_cmd_data),
    .req1_addr(req1_addr), .req1_busy(req1_busy), .req1_done(req1_done),
    .wr_ena(wr_ena), .wr_data(wr_data), .wr_cmd_data(wr_cmd_data), .wr_addr(wr_addr),
    .wr_done(wr_done), .timeout_err(timeout_err)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  typedef struct {
    logic [7:0] d;
    logic       c;
    logic [6:0] a;
    int         id;
  } exp_t;

  typedef struct {
    bit         e0;
    bit         e1;
    logic [7:0] d0;
    logic       c0;
    logic [6:0] a0;
    logic [7:0] d1;
    logic       c1;
    logic [6:0] a1;
    int         dly;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0, n_err = 0;
  bit   wr_seen = 1'b0;
  int   last_id = 0;
  int   got_done0 = 0, got_done1 = 0, got_to = 0;
  int   exp_done0 = 0, exp_done1 = 0, exp_to = 0;
  int   lg_m = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock; sample #1 after the edge and retire any writer strobe against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk_1MHz);
    #1;
    if (req0_done) got_done0++;
    if (req1_done) got_done1++;
    if (timeout_err) got_to++;
    if (wr_ena) begin
      wr_seen = 1'b1;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_wr: got wr_data 0x%0h, expected no write", wr_data);
      end else begin
        e = sb.pop_front();
        last_id = e.id;
        chk("wr_data", wr_data, e.d);
        chk("wr_cmd_data", wr_cmd_data, e.c);
        chk("wr_addr", wr_addr, e.a);
      end
    end
  endtask

  task automatic push(input int id, input logic [7:0] d, input logic c, input logic [6:0] a);
    exp_t e;
    e.d = d; e.c = c; e.a = a; e.id = id;
    sb.push_back(e);
  endtask

  task automatic drive(input bit e0, input logic [7:0] d0, input logic c0, input logic [6:0] a0,
                       input bit e1, input logic [7:0] d1, input logic c1, input logic [6:0] a1);
    req0_ena = e0; req0_data = d0; req0_cmd_data = c0; req0_addr = a0;
    req1_ena = e1; req1_data = d1; req1_cmd_data = c1; req1_addr = a1;
    tick();
    req0_ena = 1'b0;
    req1_ena = 1'b0;
  endtask

  task automatic wait_wr();
    int b = 0;
    while (!wr_seen && b < 60) begin
      tick();
      b++;
    end
    chk("wr_ena_seen", 32'(wr_seen), 32'd1);
    wr_seen = 1'b0;
  endtask

  // Writer answers dly cycles into WAIT; the next sample is the RELEASE cycle.
  task automatic finish_write(input int dly, input int id);
    repeat (dly) tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    chk("done0", 32'(req0_done), 32'(id == 0));
    chk("done1", 32'(req1_done), 32'(id == 1));
    chk("no_timeout", 32'(timeout_err), 32'd0);
    if (id == 0) exp_done0++; else exp_done1++;
  endtask

  vec_t vt[6];

  initial begin
    int first, n, b;

    vt[0] = '{1, 1, 8'h11, 1'b0, 7'h21, 8'h91, 1'b1, 7'h31, 2};
    vt[1] = '{1, 1, 8'h12, 1'b1, 7'h22, 8'h92, 1'b0, 7'h32, 1};
    vt[2] = '{1, 0, 8'h13, 1'b0, 7'h23, 8'h93, 1'b0, 7'h33, 3};
    vt[3] = '{1, 1, 8'h14, 1'b1, 7'h24, 8'h94, 1'b1, 7'h34, 2};
    vt[4] = '{0, 1, 8'h15, 1'b0, 7'h25, 8'h95, 1'b1, 7'h35, 10};
    vt[5] = '{1, 1, 8'h16, 1'b0, 7'h26, 8'h96, 1'b0, 7'h36, 10};

    #2;
    chk("reset_outputs", 32'({wr_ena, wr_data, wr_cmd_data, wr_addr, req0_busy, req0_done,
                              req1_busy, req1_done, timeout_err}), 32'd0);
    @(posedge clk_1MHz);
    #3 rst_n = 1'b1;
    tick();

    // Single write: strobe in the cycle after edge k+1, done after the writer pulse.
    push(0, 8'h28, 1'b0, 7'h27);
    req0_ena = 1'b1; req0_data = 8'h28; req0_cmd_data = 1'b0; req0_addr = 7'h27;
    tick();
    req0_ena = 1'b0;
    chk("lat_k_wr_ena", 32'(wr_ena), 32'd0);
    chk("lat_k_busy0", 32'(req0_busy), 32'd1);
    tick();
    chk("lat_k1_wr_ena", 32'(wr_ena), 32'd1);
    wr_seen = 1'b0;
    lg_m = 0;
    finish_write(4, 0);
    tick();
    chk("single_busy0_low", 32'(req0_busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      if (vt[i].e0 && vt[i].e1) begin
        first = (lg_m == 1) ? 0 : 1;
        if (first == 0) begin
          push(0, vt[i].d0, vt[i].c0, vt[i].a0);
          push(1, vt[i].d1, vt[i].c1, vt[i].a1);
        end else begin
          push(1, vt[i].d1, vt[i].c1, vt[i].a1);
          push(0, vt[i].d0, vt[i].c0, vt[i].a0);
        end
        lg_m = 1 - first;
        n = 2;
      end else if (vt[i].e0) begin
        push(0, vt[i].d0, vt[i].c0, vt[i].a0);
        lg_m = 0;
        n = 1;
      end else begin
        push(1, vt[i].d1, vt[i].c1, vt[i].a1);
        lg_m = 1;
        n = 1;
      end
      drive(vt[i].e0, vt[i].d0, vt[i].c0, vt[i].a0, vt[i].e1, vt[i].d1, vt[i].c1, vt[i].a1);
      for (int k = 0; k < n; k++) begin
        wait_wr();
        finish_write(vt[i].dly, last_id);
      end
      tick();
    end

    // Second request while pending is dropped.
    push(1, 8'hB1, 1'b1, 7'h51);
    drive(1'b0, 8'h00, 1'b0, 7'h00, 1'b1, 8'hB1, 1'b1, 7'h51);
    drive(1'b0, 8'h00, 1'b0, 7'h00, 1'b1, 8'hB2, 1'b0, 7'h52);
    chk("drop_busy1", 32'(req1_busy), 32'd1);
    wait_wr();
    finish_write(3, 1);
    lg_m = 1;
    repeat (4) tick();
    chk("drop_busy1_low", 32'(req1_busy), 32'd0);
    chk("drop_sb_empty", 32'(sb.size()), 32'd0);

    // Both re-request in every RELEASE cycle: grants must alternate.
    first = (lg_m == 1) ? 0 : 1;
    if (first == 0) begin
      push(0, 8'h50, 1'b0, 7'h10);
      push(1, 8'h60, 1'b1, 7'h20);
    end else begin
      push(1, 8'h60, 1'b1, 7'h20);
      push(0, 8'h50, 1'b0, 7'h10);
    end
    drive(1'b1, 8'h50, 1'b0, 7'h10, 1'b1, 8'h60, 1'b1, 7'h20);
    for (int i = 0; i < 6; i++) begin
      wait_wr();
      finish_write(1, first ^ (i & 1));
      if (i < 4) begin
        if ((first ^ (i & 1)) == 0) push(0, 8'h51 + 8'(i), 1'b0, 7'h10);
        else push(1, 8'h61 + 8'(i), 1'b1, 7'h20);
        drive(1'b1, 8'h51 + 8'(i), 1'b0, 7'h10, 1'b1, 8'h61 + 8'(i), 1'b1, 7'h20);
      end
    end
    lg_m = first ^ 1;
    tick();

    // Timeout: ten WAIT cycles without wr_done, then a late wr_done is ignored.
    push(0, 8'h77, 1'b1, 7'h11);
    drive(1'b1, 8'h77, 1'b1, 7'h11, 1'b0, 8'h00, 1'b0, 7'h00);
    wait_wr();
    b = 0;
    while (!req0_done && b < 40) begin
      tick();
      b++;
    end
    chk("to_wait_cycles", 32'(b - 1), 32'd10);
    chk("to_err_pulse", 32'(timeout_err), 32'd1);
    exp_done0++;
    exp_to++;
    lg_m = 0;
    tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    repeat (3) tick();
    chk("to_busy0_low", 32'(req0_busy), 32'd0);

    // Reset in WAIT: outputs clear at once, no done, lg back to 1.
    push(1, 8'h99, 1'b0, 7'h42);
    drive(1'b0, 8'h00, 1'b0, 7'h00, 1'b1, 8'h99, 1'b0, 7'h42);
    wait_wr();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 32'({wr_ena, wr_data, wr_cmd_data, wr_addr, req0_busy, req0_done,
                                  req1_busy, req1_done, timeout_err}), 32'd0);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    lg_m = 1;
    push(0, 8'hC0, 1'b0, 7'h03);
    push(1, 8'hC1, 1'b1, 7'h04);
    drive(1'b1, 8'hC0, 1'b0, 7'h03, 1'b1, 8'hC1, 1'b1, 7'h04);
    for (int k = 0; k < 2; k++) begin
      wait_wr();
      finish_write(2, last_id);
    end
    repeat (3) tick();

    chk("total_done0", 32'(got_done0), 32'(exp_done0));
    chk("total_done1", 32'(got_done1), 32'(exp_done1));
    chk("total_timeout", 32'(got_to), 32'(exp_to));
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
